// File: rtl/adder_tree_seq.sv
// adder_tree_seq: multi-pass sequencer for the 11-lane combinational adder tree.
// Accepts one window of N_TERMS signed products. Presents the window to the tree in
// 11-lane slices, one slice per cycle. Accumulates the per-pass sums and returns one
// DW-bit sum per window. All arithmetic wraps modulo 2^DW.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   in_valid_i   window valid
//   in_ready_o   window accepted when in_valid_i & in_ready_o
//   in_data_i    N_TERMS signed products, term k at [(k+1)*DW-1 -: DW]
//   tree_data_o  slice driven to the adder tree, lane j at [(j+1)*DW-1 -: DW]
//   tree_sum_i   combinational sum returned by the tree
//   out_valid_o  result valid
//   out_ready_i  result consumed when out_valid_o & out_ready_i
//   out_sum_o    signed window sum
//   busy_o       high while passes are running
module adder_tree_seq #(
  parameter int unsigned N_TERMS = 25,
  parameter int unsigned DW      = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [N_TERMS*DW-1:0]   in_data_i,
  output logic [11*DW-1:0]        tree_data_o,
  input  logic [DW-1:0]           tree_sum_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [DW-1:0]           out_sum_o,
  output logic                    busy_o
);

  localparam int unsigned Lanes = 11;
  localparam int unsigned NPass = (N_TERMS + Lanes - 1) / Lanes;
  localparam int unsigned PassW = (NPass > 1) ? $clog2(NPass) : 1;
  localparam int unsigned SliceW = Lanes * DW;
  localparam int unsigned PadW  = NPass * SliceW;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                state_q, state_d;
  logic [N_TERMS*DW-1:0] win_q;
  logic [PassW-1:0]      pass_q;
  logic [DW-1:0]         acc_q;
  logic [DW-1:0]         out_sum_q;
  logic                  out_valid_q;

  logic                  accept;
  logic                  last_pass;
  logic [PadW-1:0]       win_pad;
  logic [SliceW-1:0]     slice [NPass];

  // Zero-extend the window to a whole number of slices so the last pass sees
  // zeros in the unused lanes rather than anything stale.
  assign win_pad = PadW'(win_q);

  for (genvar p = 0; p < NPass; p++) begin : g_slice
    assign slice[p] = win_pad[p*SliceW +: SliceW];
  end

  assign last_pass = (pass_q == PassW'(NPass - 1));
  assign accept    = in_valid_i & in_ready_o;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid_i) state_d = StRun;
      StRun:  if (last_pass) state_d = StDone;
      StDone: begin
        if (out_ready_i) state_d = in_valid_i ? StRun : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready_o  = 1'b0;
    busy_o      = 1'b0;
    tree_data_o = '0;
    unique case (state_q)
      StIdle: in_ready_o = 1'b1;
      StRun: begin
        busy_o      = 1'b1;
        tree_data_o = slice[pass_q];
      end
      // Retiring the result frees the window buffer in the same edge.
      StDone: in_ready_o = out_ready_i;
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      win_q       <= '0;
      pass_q      <= '0;
      acc_q       <= '0;
      out_sum_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        win_q  <= in_data_i;
        acc_q  <= '0;
        pass_q <= '0;
      end else if (state_q == StRun) begin
        acc_q  <= acc_q + tree_sum_i;
        pass_q <= last_pass ? '0 : pass_q + 1'b1;
      end

      if (state_q == StRun && last_pass) begin
        out_sum_q   <= acc_q + tree_sum_i;
        out_valid_q <= 1'b1;
      end else if (state_q == StDone && out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_sum_o   = out_sum_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_adder_tree_seq.sv
// tb_adder_tree_seq: directed bench for adder_tree_seq (N_TERMS=25, DW=32).
// The bench models the combinational adder tree as a plain lane sum. Inputs are driven
// and outputs sampled on the falling edge.
module tb_adder_tree_seq;

  localparam int unsigned N  = 25;
  localparam int unsigned DW = 32;
  localparam int unsigned L  = 11;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [N*DW-1:0]   in_data;
  logic [L*DW-1:0]   tree_data;
  logic [DW-1:0]     tree_sum;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_sum;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int hs     = 0;
  int hs0;
  int seen;

  adder_tree_seq #(.N_TERMS(N), .DW(DW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .tree_data_o (tree_data),
    .tree_sum_i  (tree_sum),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_sum_o   (out_sum),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder tree model
  always_comb begin
    tree_sum = '0;
    for (int j = 0; j < L; j++) tree_sum = tree_sum + tree_data[j*DW +: DW];
  end

  always @(posedge clk) if (!rst && out_valid && out_ready) hs++;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] fill(input logic [31:0] v);
    logic [N*DW-1:0] d;
    for (int k = 0; k < N; k++) d[k*DW +: DW] = v;
    return d;
  endfunction

  // Present a window in IDLE; returns at the falling edge of the first RUN cycle.
  task automatic send(input logic [N*DW-1:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = fill(32'hDEAD_BEEF);  // must not affect the window in flight
  endtask

  logic [N*DW-1:0] d;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_sum", out_sum, 32'd0);
    check("rst_tree_zero", 32'(|tree_data), 32'd0);
    rst = 1'b0;

    // 1: all ones
    send(fill(32'd1));
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_in_ready", 32'(in_ready), 32'd0);
    check("t1_pass0", tree_sum, 32'd11);
    @(negedge clk);
    check("t1_pass1", tree_sum, 32'd11);
    @(negedge clk);
    check("t1_pass2", tree_sum, 32'd3);
    check("t1_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_sum", out_sum, 32'd25);
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_tree_zero", 32'(|tree_data), 32'd0);
    @(negedge clk);
    check("t1_retired", 32'(out_valid), 32'd0);
    check("t1_ready", 32'(in_ready), 32'd1);

    // 2: all minus one, padding lanes on the last pass
    send(fill(32'hFFFF_FFFF));
    check("t2_pass0", tree_sum, 32'hFFFF_FFF5);
    @(negedge clk);
    check("t2_pass1", tree_sum, 32'hFFFF_FFF5);
    @(negedge clk);
    check("t2_pad", 32'(|tree_data[L*DW-1:3*DW]), 32'd0);
    check("t2_lane2", tree_data[3*DW-1 -: DW], 32'hFFFF_FFFF);
    check("t2_pass2", tree_sum, 32'hFFFF_FFFD);
    @(negedge clk);
    check("t2_sum", out_sum, 32'hFFFF_FFE7);
    @(negedge clk);

    // 3: wrap-around
    d = '0;
    d[0*DW +: DW]  = 32'h7FFF_FFFF;
    d[11*DW +: DW] = 32'h7FFF_FFFF;
    send(d);
    repeat (3) @(negedge clk);
    check("t3_valid", 32'(out_valid), 32'd1);
    check("t3_sum", out_sum, 32'hFFFF_FFFE);
    @(negedge clk);

    // 4: backpressure in DONE; terms 1..25 sum to 325
    out_ready = 1'b0;
    for (int k = 0; k < N; k++) d[k*DW +: DW] = 32'(k + 1);
    send(d);
    repeat (3) @(negedge clk);
    check("t4_valid", 32'(out_valid), 32'd1);
    check("t4_sum", out_sum, 32'd325);
    in_valid = 1'b1;
    in_data  = fill(32'd7);
    hs0 = hs;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t4_hold_valid", 32'(out_valid), 32'd1);
      check("t4_hold_sum", out_sum, 32'd325);
      check("t4_hold_ready", 32'(in_ready), 32'd0);
      check("t4_hold_busy", 32'(busy), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("t4_release_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("t4_hs_count", 32'(hs - hs0), 32'd1);
    check("t4_done_valid", 32'(out_valid), 32'd0);
    check("t4_idle_busy", 32'(busy), 32'd0);

    // 5: back-to-back windows chained from DONE
    send(fill(32'd1));
    repeat (3) @(negedge clk);
    check("t5_a_valid", 32'(out_valid), 32'd1);
    check("t5_a_sum", out_sum, 32'd25);
    check("t5_chain_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = fill(32'd2);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = fill(32'd9);
    check("t5_b_busy0", 32'(busy), 32'd1);
    check("t5_b_pass0", tree_sum, 32'd22);
    check("t5_b_gap_valid", 32'(out_valid), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("t5_b_busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    check("t5_b_valid", 32'(out_valid), 32'd1);
    check("t5_b_sum", out_sum, 32'd50);
    @(negedge clk);

    // 6: reset during pass 1
    hs0 = hs;
    send(fill(32'd1));
    @(negedge clk);
    check("t6_pass1", tree_sum, 32'd11);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_sum", out_sum, 32'd0);
    check("t6_rst_tree", 32'(|tree_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("t6_no_result", 32'(seen), 32'd0);
    check("t6_no_hs", 32'(hs - hs0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
